// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared constants and types for the 1024x768 video pipeline.
//   H_DISP / V_DISP   visible area of the timing driver
//   FRAME_PIXELS      visible pixels per frame (pops expected per frame)
//   PREFILL_LEVEL     read-FIFO fill level required before a frame may stream
//   RESTART_CYCLES    width of the frame_restart pulse, in pixel clocks
//   RGB565_RED/BLACK  colours used for underflow and blanking
//   frame_state_t     frame reader state encoding
// ---------------------------------------------------------------------------
package video_pkg;

    localparam int H_DISP = 1024;
    localparam int V_DISP = 768;

    localparam int unsigned FRAME_PIXELS = H_DISP * V_DISP;

    localparam logic [9:0] PREFILL_LEVEL  = 10'd256;
    localparam int         RESTART_CYCLES = 4;

    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_BLACK = 16'h0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTART = 2'd1,
        FILL    = 2'd2,
        ACTIVE  = 2'd3
    } frame_state_t;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk    clock
//   rst    synchronous reset, active-high, clears the count
//   inc    count enable (+1 per cycle while high)
//   count  current count, saturating at 2**W-1
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count increments until all bits are set, then holds so that a long
    // run of events never wraps back to a small, misleading value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/video_frame_reader.sv
// ---------------------------------------------------------------------------
// video_frame_reader
// Pixel source in front of the 1024x768 timing driver. Pops RGB565 words from
// a show-ahead read FIFO, answers each data_req with pixel_data one cycle
// later, restarts the frame-buffer read at every frame start and tracks
// whether each frame was delivered cleanly.
//   pixel_clk      pixel clock (single domain)
//   sys_rst        synchronous reset, active-high
//   data_req       pixel request, one cycle ahead of video_de
//   video_vs       vertical sync, active-low; falling edge marks frame start
//   pixel_data     registered RGB565 pixel to the timing driver
//   fifo_rd_en     pop strobe to the read FIFO (combinational)
//   fifo_rd_data   FIFO head word, valid whenever !fifo_empty
//   fifo_empty     FIFO empty flag
//   fifo_usedw     FIFO fill level
//   frame_restart  flush FIFO / rewind read address to frame base
//   frame_ok       previous frame had exactly FRAME_PIXELS pops, no errors
//   underflow_cnt  saturating count of underflows since reset
// ---------------------------------------------------------------------------
module video_frame_reader #(
    parameter int unsigned FRAME_PIXELS    = video_pkg::FRAME_PIXELS,
    parameter logic [9:0]  PREFILL_LEVEL   = video_pkg::PREFILL_LEVEL,
    parameter int          RESTART_CYCLES  = video_pkg::RESTART_CYCLES,
    parameter logic [15:0] UNDERFLOW_COLOR = video_pkg::RGB565_RED,
    parameter logic [15:0] BLANK_COLOR     = video_pkg::RGB565_BLACK
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    input  logic        data_req,
    input  logic        video_vs,
    output logic [15:0] pixel_data,
    output logic        fifo_rd_en,
    input  logic [15:0] fifo_rd_data,
    input  logic        fifo_empty,
    input  logic [9:0]  fifo_usedw,
    output logic        frame_restart,
    output logic        frame_ok,
    output logic [15:0] underflow_cnt
);

    import video_pkg::*;

    localparam int RC_W = $clog2(RESTART_CYCLES + 1);

    frame_state_t state;
    frame_state_t next_state;

    logic            vs_d;
    logic            vs_fall;
    logic            frame_edge;
    logic            underflow;
    logic            early_req;
    logic            overrun;
    logic [RC_W-1:0] restart_cnt;
    logic [19:0]     pop_cnt;
    logic            frame_err;

    // A falling vsync edge always blocks a pop in the same cycle, but it only
    // ends a frame when we are not already in the middle of a restart.
    assign vs_fall    = vs_d & ~video_vs;
    assign frame_edge = vs_fall && (state != RESTART);

    // Error sources for the current frame; all are suppressed in the vsync
    // edge cycle because that cycle belongs to neither frame.
    assign underflow = data_req && (state == ACTIVE) && fifo_empty && !vs_fall;
    assign early_req = data_req && (state != ACTIVE) && !vs_fall;
    assign overrun   = fifo_rd_en && (pop_cnt == 20'(FRAME_PIXELS));

    // State register for the frame sequencer.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe logic. Any frame edge (outside RESTART) forces a
    // restart; otherwise the sequencer walks RESTART -> FILL -> ACTIVE and
    // then serves requests until the next edge. IDLE is only left via an edge
    // so a reset in mid-frame waits for a clean frame start.
    always_comb begin
        next_state    = state;
        frame_restart = 1'b0;
        fifo_rd_en    = 1'b0;

        case (state)
            IDLE: begin
                next_state = IDLE;
            end
            RESTART: begin
                frame_restart = 1'b1;
                if (restart_cnt == RC_W'(RESTART_CYCLES - 1)) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (fifo_usedw >= PREFILL_LEVEL) begin
                    next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                fifo_rd_en = data_req && !fifo_empty && !vs_fall;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (frame_edge) begin
            next_state = RESTART;
        end
    end

    // Restart pulse timer: held at zero outside RESTART so every entry into
    // RESTART produces a full-length pulse.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            restart_cnt <= '0;
        end else if (state != RESTART) begin
            restart_cnt <= '0;
        end else begin
            restart_cnt <= restart_cnt + RC_W'(1);
        end
    end

    // Pixel output register. A popped word goes out directly; an underflow
    // shows red so the glitch is visible on screen; requests outside ACTIVE
    // (including the vsync edge cycle) get the blank colour; idle cycles are 0.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            vs_d       <= 1'b1;
            pixel_data <= 16'h0000;
        end else begin
            vs_d <= video_vs;
            if (fifo_rd_en) begin
                pixel_data <= fifo_rd_data;
            end else if (underflow) begin
                pixel_data <= UNDERFLOW_COLOR;
            end else if (data_req) begin
                pixel_data <= BLANK_COLOR;
            end else begin
                pixel_data <= 16'h0000;
            end
        end
    end

    // Frame bookkeeping. At each frame edge the previous frame is judged
    // (exact pop count and no error) and the counters start over; between
    // edges pops are counted and any underflow, early request or overrun
    // marks the frame as bad. The pop counter may wrap after an overrun, but
    // by then frame_err is already set.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            pop_cnt   <= '0;
            frame_err <= 1'b0;
            frame_ok  <= 1'b0;
        end else if (frame_edge) begin
            frame_ok  <= (pop_cnt == 20'(FRAME_PIXELS)) && !frame_err;
            pop_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (fifo_rd_en) begin
                pop_cnt <= pop_cnt + 20'd1;
            end
            if (underflow || early_req || overrun) begin
                frame_err <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W(16)
    ) u_underflow_cnt (
        .clk   (pixel_clk),
        .rst   (sys_rst),
        .inc   (underflow),
        .count (underflow_cnt)
    );

endmodule
